// File: rtl/flood_menu_ctrl_pkg.sv
// Shared types and constants for the Flood-It menu/selection controller.
// Latency: n/a (types, constants and a pure budget function).
// Backpressure: n/a.
package flood_menu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_MENU  = 3'd1,
        S_INIT  = 3'd2,
        S_BEGIN = 3'd3,
        S_PLAY  = 3'd4
    } state_t;

    localparam int SIZE_W     = 5;
    localparam int CNUM_W     = 4;
    localparam int TRY_W      = 8;
    localparam int PROD_W     = 14;
    localparam int BUDGET_MUL = 77;

    // Move budget: roughly 0.3 moves per cell-colour, never below one move.
    function automatic logic [TRY_W-1:0] calc_budget(input logic [SIZE_W-1:0] size,
                                                     input logic [CNUM_W-1:0] cnum);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(size) * PROD_W'(cnum) * PROD_W'(BUDGET_MUL);
        if (prod[PROD_W-1:8] == '0)
            calc_budget = TRY_W'(1);
        else
            calc_budget = TRY_W'(prod[PROD_W-1:8]);
    endfunction

endpackage

// File: rtl/flood_menu_ctrl_if.sv
// Signal bundle between the menu controller and buttons/randomiser/game logic.
// Latency: n/a (wiring only).
// Backpressure: new-game and colour-select are level handshakes held until acknowledged.
interface flood_menu_ctrl_if
    import flood_menu_ctrl_pkg::*;
#(
    parameter int NUM_COLORS_MAX = 8,
    parameter int CW             = $clog2(NUM_COLORS_MAX)
);
    logic                      UP, DOWN, LEFT, RIGHT, CENTER;
    logic [NUM_COLORS_MAX-1:0] SW;
    logic                      BOARD_READY;
    logic                      INITIALIZE_BOARD;
    logic                      INITIALIZED;
    logic                      BEGIN_GAME;
    logic                      ACK_BEGIN_GAME;
    logic                      CURRENTLY_CHANGING_COLOR;
    logic                      GAME_OVER;
    logic                      COLOR_SEL_SIG;
    logic [CW-1:0]             COLOR_SELECTED;
    logic [SIZE_W-1:0]         SIZE;
    logic [CNUM_W-1:0]         COLOR_NUM;
    logic [SIZE_W-1:0]         FINAL_SIZE;
    logic [CNUM_W-1:0]         FINAL_COLOR_NUM;
    logic                      MODE;
    logic                      SORC;
    logic [TRY_W-1:0]          TRIES;
    logic [TRY_W-1:0]          TOTAL_TRIES;
    logic                      OUT_OF_TRIES;

    modport master (
        input  UP, DOWN, LEFT, RIGHT, CENTER, SW, BOARD_READY, INITIALIZED,
               ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, GAME_OVER,
        output INITIALIZE_BOARD, BEGIN_GAME, COLOR_SEL_SIG, COLOR_SELECTED,
               SIZE, COLOR_NUM, FINAL_SIZE, FINAL_COLOR_NUM, MODE, SORC,
               TRIES, TOTAL_TRIES, OUT_OF_TRIES
    );

    modport slave (
        output UP, DOWN, LEFT, RIGHT, CENTER, SW, BOARD_READY, INITIALIZED,
               ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, GAME_OVER,
        input  INITIALIZE_BOARD, BEGIN_GAME, COLOR_SEL_SIG, COLOR_SELECTED,
               SIZE, COLOR_NUM, FINAL_SIZE, FINAL_COLOR_NUM, MODE, SORC,
               TRIES, TOTAL_TRIES, OUT_OF_TRIES
    );
endinterface

// File: rtl/flood_menu_ctrl_btn_edge_repeat.sv
// Button rising-edge detector with optional hold-to-repeat step generation.
// Latency: o_step is combinational in the cycle the button is first seen high.
// Backpressure: none; steps are single-cycle pulses and are never stored.
module btn_edge_repeat #(
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter bit EN_REPEAT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_rep_en,
    output logic o_step
);
    localparam int MAXC  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic             r_prev;
    logic             r_first;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;
    logic             w_held;
    logic             w_rep;

    // r_cnt equals the number of cycles since the last step while the button stays down.
    assign w_edge = i_btn & ~r_prev;
    assign w_held = EN_REPEAT & i_rep_en & i_btn & r_prev;
    assign w_rep  = w_held & (r_cnt == (r_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD)));
    assign o_step = w_edge | w_rep;

    // Track the previous level and the hold timer; release clears the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_first <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_prev <= i_btn;
            if (w_edge) begin
                r_cnt   <= CNT_W'(1);
                r_first <= 1'b1;
            end else if (w_rep) begin
                r_cnt   <= CNT_W'(1);
                r_first <= 1'b0;
            end else if (w_held) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/flood_menu_ctrl.sv
// Flood-It menu, new-game handshake and per-move colour-select controller.
// Latency: button/switch edges act on the next clock edge; budget follows FINAL_* by one cycle.
// Backpressure: one colour request in flight; toggles while busy/locked are dropped, not queued.
module flood_menu_ctrl
    import flood_menu_ctrl_pkg::*;
#(
    parameter int NUM_COLORS_MAX = 8,
    parameter int COLORS_MIN     = 3,
    parameter int COLORS_DEFAULT = 6,
    parameter int SIZE_MIN       = 2,
    parameter int SIZE_MAX       = 26,
    parameter int SIZE_STEP      = 4,
    parameter int SIZE_DEFAULT   = 14,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_PERIOD  = 10000000,
    parameter int CW             = $clog2(NUM_COLORS_MAX)
) (
    input  logic            MASTER_CLOCK,
    input  logic            RESET_N,
    flood_menu_ctrl_if.master bus
);
    state_t                    r_state, w_next;
    logic                      w_latch;
    logic                      w_up, w_down, w_left, w_right, w_center;
    logic                      w_menu, w_inc, w_dec;
    logic [SIZE_W-1:0]         r_size, r_final_size, w_size_up, w_size_dn;
    logic [CNUM_W-1:0]         r_cnum, r_final_cnum, w_cnum_up, w_cnum_dn;
    logic                      r_sorc;
    logic [TRY_W-1:0]          r_tries, r_total;
    logic                      r_sel_sig;
    logic [CW-1:0]             r_selected;
    logic [NUM_COLORS_MAX-1:0] r_sw_snap, w_mask, w_cand;
    logic [CW-1:0]             w_win_idx;
    logic                      w_win_vld, w_issue;

    assign w_menu = (r_state == S_MENU);

    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .EN_REPEAT(1'b1))
        u_up     (.clk(MASTER_CLOCK), .rst_n(RESET_N), .i_btn(bus.UP),     .i_rep_en(w_menu), .o_step(w_up));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .EN_REPEAT(1'b1))
        u_down   (.clk(MASTER_CLOCK), .rst_n(RESET_N), .i_btn(bus.DOWN),   .i_rep_en(w_menu), .o_step(w_down));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .EN_REPEAT(1'b0))
        u_left   (.clk(MASTER_CLOCK), .rst_n(RESET_N), .i_btn(bus.LEFT),   .i_rep_en(1'b0),   .o_step(w_left));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .EN_REPEAT(1'b0))
        u_right  (.clk(MASTER_CLOCK), .rst_n(RESET_N), .i_btn(bus.RIGHT),  .i_rep_en(1'b0),   .o_step(w_right));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .EN_REPEAT(1'b0))
        u_center (.clk(MASTER_CLOCK), .rst_n(RESET_N), .i_btn(bus.CENTER), .i_rep_en(1'b0),   .o_step(w_center));

    // FSM state register.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_BOOT;
        else          r_state <= w_next;
    end

    // Next-state decode; w_latch snapshots the menu values into FINAL_* for a new game.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (!bus.INITIALIZED) begin
                    w_latch = 1'b1;
                    w_next  = S_INIT;
                end else begin
                    w_next = S_PLAY;
                end
            end
            S_MENU: begin
                if (w_center) begin
                    w_latch = 1'b1;
                    w_next  = S_INIT;
                end else if (w_right) begin
                    w_next = S_PLAY;
                end
            end
            S_INIT:  if (bus.BOARD_READY)    w_next = S_BEGIN;
            S_BEGIN: if (bus.ACK_BEGIN_GAME) w_next = S_PLAY;
            S_PLAY:  if (w_right && bus.INITIALIZED && !r_sel_sig) w_next = S_MENU;
            default: w_next = S_BOOT;
        endcase
    end

    // Wrapping neighbours of the two editable fields.
    always_comb begin
        w_size_up = (r_size == SIZE_W'(SIZE_MAX)) ? SIZE_W'(SIZE_MIN) : r_size + SIZE_W'(SIZE_STEP);
        w_size_dn = (r_size == SIZE_W'(SIZE_MIN)) ? SIZE_W'(SIZE_MAX) : r_size - SIZE_W'(SIZE_STEP);
        w_cnum_up = (r_cnum == CNUM_W'(NUM_COLORS_MAX)) ? CNUM_W'(COLORS_MIN) : r_cnum + CNUM_W'(1);
        w_cnum_dn = (r_cnum == CNUM_W'(COLORS_MIN)) ? CNUM_W'(NUM_COLORS_MAX) : r_cnum - CNUM_W'(1);
    end

    // Opposing UP and DOWN steps in the same cycle cancel out.
    assign w_inc = w_menu & w_up & ~w_down;
    assign w_dec = w_menu & w_down & ~w_up;

    // Menu fields, game snapshot and the derived move budget.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_size       <= SIZE_W'(SIZE_DEFAULT);
            r_cnum       <= CNUM_W'(COLORS_DEFAULT);
            r_final_size <= SIZE_W'(SIZE_DEFAULT);
            r_final_cnum <= CNUM_W'(COLORS_DEFAULT);
            r_sorc       <= 1'b0;
            r_total      <= calc_budget(SIZE_W'(SIZE_DEFAULT), CNUM_W'(COLORS_DEFAULT));
        end else begin
            if (w_inc) begin
                if (r_sorc) r_size <= w_size_up;
                else        r_cnum <= w_cnum_up;
            end else if (w_dec) begin
                if (r_sorc) r_size <= w_size_dn;
                else        r_cnum <= w_cnum_dn;
            end
            if (w_menu && w_left) r_sorc <= ~r_sorc;
            if (w_latch) begin
                r_final_size <= r_size;
                r_final_cnum <= r_cnum;
            end
            r_total <= calc_budget(r_final_size, r_final_cnum);
        end
    end

    // Candidate colours: switches that changed this cycle and are in play for this game.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_COLORS_MAX; i++)
            w_mask[i] = (i < int'(r_final_cnum));
    end
    assign w_cand = (bus.SW ^ r_sw_snap) & w_mask;

    // Lowest-index candidate wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = NUM_COLORS_MAX - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_vld = 1'b1;
                w_win_idx = CW'(i);
            end
        end
    end

    assign w_issue = (r_state == S_PLAY) & w_win_vld & ~r_sel_sig & ~bus.CURRENTLY_CHANGING_COLOR
                   & ~bus.GAME_OVER & (r_tries < r_total);

    // Switch snapshot, move counter and the colour-select request/acknowledge.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_snap  <= '0;
            r_tries    <= '0;
            r_sel_sig  <= 1'b0;
            r_selected <= '0;
        end else begin
            r_sw_snap <= bus.SW;
            if (r_state == S_INIT)
                r_tries <= '0;
            else if (w_issue)
                r_tries <= r_tries + TRY_W'(1);
            if (w_issue) begin
                r_sel_sig  <= 1'b1;
                r_selected <= w_win_idx;
            end else if (r_sel_sig && bus.CURRENTLY_CHANGING_COLOR) begin
                r_sel_sig <= 1'b0;
            end
        end
    end

    assign bus.INITIALIZE_BOARD = (r_state == S_INIT);
    assign bus.BEGIN_GAME       = (r_state == S_BEGIN);
    assign bus.MODE             = ~w_menu;
    assign bus.SORC             = r_sorc;
    assign bus.SIZE             = r_size;
    assign bus.COLOR_NUM        = r_cnum;
    assign bus.FINAL_SIZE       = r_final_size;
    assign bus.FINAL_COLOR_NUM  = r_final_cnum;
    assign bus.TRIES            = r_tries;
    assign bus.TOTAL_TRIES      = r_total;
    assign bus.COLOR_SEL_SIG    = r_sel_sig;
    assign bus.COLOR_SELECTED   = r_selected;
    assign bus.OUT_OF_TRIES     = (r_tries == r_total) & ~bus.GAME_OVER;
endmodule

// File: tb/tb_flood_menu_ctrl.sv
// Self-checking bench for flood_menu_ctrl against a rule-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_flood_menu_ctrl;
    localparam int D     = 20;
    localparam int P     = 6;
    localparam int NCMAX = 8;
    localparam int CMIN  = 3;
    localparam int SMIN  = 2;
    localparam int SMAX  = 26;
    localparam int SSTEP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flood_menu_ctrl_if #(.NUM_COLORS_MAX(NCMAX)) bus();

    flood_menu_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .MASTER_CLOCK(clk),
        .RESET_N     (rst_n),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_size, m_cnum, m_sorc, m_fsize, m_fcnum, m_tries, m_sel, m_csel;

    function automatic int model_budget(input int s, input int c);
        int v;
        v = ((s * c * 77) / 256) % 256;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int wrap_size(input int s, input int dir);
        int n, idx;
        n   = (SMAX - SMIN) / SSTEP + 1;
        idx = ((s - SMIN) / SSTEP + dir + n) % n;
        return SMIN + idx * SSTEP;
    endfunction

    function automatic int wrap_cnum(input int c, input int dir);
        int n;
        n = NCMAX - CMIN + 1;
        return CMIN + ((c - CMIN + dir + n) % n);
    endfunction

    // Steps delivered while a button is held n cycles (edge, after D, then every P).
    function automatic int hold_steps(input int n);
        if (n <= 0) return 0;
        if (n - 1 < D) return 1;
        return 2 + (n - 1 - D) / P;
    endfunction

    function automatic int total_now();
        return model_budget(m_fsize, m_fcnum);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_size = 14; m_cnum = 6; m_fsize = 14; m_fcnum = 6;
        m_sorc = 0; m_tries = 0; m_sel = 0; m_csel = 0;
    endtask

    task automatic press(input logic up, input logic dn, input logic lf, input logic rt, input logic ce);
        bus.UP = up; bus.DOWN = dn; bus.LEFT = lf; bus.RIGHT = rt; bus.CENTER = ce;
        tick();
        bus.UP = 0; bus.DOWN = 0; bus.LEFT = 0; bus.RIGHT = 0; bus.CENTER = 0;
        tick();
        if (up != dn) begin
            if (m_sorc == 1) m_size = wrap_size(m_size, up ? 1 : -1);
            else             m_cnum = wrap_cnum(m_cnum, up ? 1 : -1);
        end
        if (lf) m_sorc = 1 - m_sorc;
    endtask

    task automatic go_menu();
        press(0, 0, 0, 1, 0);
        n_vec++;
        if (bus.MODE !== 1'b0) begin n_err++; $display("FAIL go_menu MODE got %0d want 0", bus.MODE); end
    endtask

    task automatic set_fields(input int ws, input int wc);
        if (m_sorc == 0) press(0, 0, 1, 0, 0);
        for (int k = 0; k < 8 && m_size != ws; k++) press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        for (int k = 0; k < 8 && m_cnum != wc; k++) press(1, 0, 0, 0, 0);
    endtask

    task automatic start_game();
        press(0, 0, 0, 0, 1);
        m_fsize = m_size; m_fcnum = m_cnum; m_tries = 0;
        n_vec++;
        if (bus.INITIALIZE_BOARD !== 1'b1 || bus.TRIES !== 8'd0) begin
            n_err++; $display("FAIL start_init ib=%0d tries=%0d want 1,0", bus.INITIALIZE_BOARD, bus.TRIES);
        end
        bus.BOARD_READY = 1; tick(); bus.BOARD_READY = 0;
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b1 || bus.INITIALIZE_BOARD !== 1'b0) begin
            n_err++; $display("FAIL start_begin bg=%0d ib=%0d want 1,0", bus.BEGIN_GAME, bus.INITIALIZE_BOARD);
        end
        bus.ACK_BEGIN_GAME = 1; tick(); bus.ACK_BEGIN_GAME = 0;
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b0 || bus.MODE !== 1'b1) begin
            n_err++; $display("FAIL start_play bg=%0d mode=%0d want 0,1", bus.BEGIN_GAME, bus.MODE);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.UP = 0; bus.DOWN = 0; bus.LEFT = 0; bus.RIGHT = 0; bus.CENTER = 0; bus.SW = '0;
        bus.BOARD_READY = 0; bus.INITIALIZED = 0; bus.ACK_BEGIN_GAME = 0;
        bus.CURRENTLY_CHANGING_COLOR = 0; bus.GAME_OVER = 0;
        model_reset();
        repeat (3) tick();
        n_vec++;
        if (bus.SIZE !== 5'(14) || bus.COLOR_NUM !== 4'(6) || bus.FINAL_SIZE !== 5'(14)
            || bus.FINAL_COLOR_NUM !== 4'(6)) begin
            n_err++; $display("FAIL reset_fields got %0d %0d %0d %0d want 14 6 14 6",
                              bus.SIZE, bus.COLOR_NUM, bus.FINAL_SIZE, bus.FINAL_COLOR_NUM);
        end
        n_vec++;
        if (bus.TOTAL_TRIES !== 8'(model_budget(14, 6)) || bus.TRIES !== 8'd0 || bus.MODE !== 1'b1
            || bus.SORC !== 1'b0 || bus.OUT_OF_TRIES !== 1'b0) begin
            n_err++; $display("FAIL reset_misc total=%0d tries=%0d mode=%0d sorc=%0d oot=%0d want 25 0 1 0 0",
                              bus.TOTAL_TRIES, bus.TRIES, bus.MODE, bus.SORC, bus.OUT_OF_TRIES);
        end
        n_vec++;
        if (bus.INITIALIZE_BOARD !== 1'b0 || bus.BEGIN_GAME !== 1'b0 || bus.COLOR_SEL_SIG !== 1'b0
            || bus.COLOR_SELECTED !== 3'd0) begin
            n_err++; $display("FAIL reset_hs ib=%0d bg=%0d sel=%0d csel=%0d want all 0",
                              bus.INITIALIZE_BOARD, bus.BEGIN_GAME, bus.COLOR_SEL_SIG, bus.COLOR_SELECTED);
        end
        rst_n = 1;
        tick();
        repeat ($urandom_range(0, 3)) tick();
        n_vec++;
        if (bus.INITIALIZE_BOARD !== 1'b1 || bus.BEGIN_GAME !== 1'b0) begin
            n_err++; $display("FAIL boot_init ib=%0d bg=%0d want 1,0", bus.INITIALIZE_BOARD, bus.BEGIN_GAME);
        end
        bus.BOARD_READY = 1; tick(); bus.BOARD_READY = 0;
        repeat ($urandom_range(1, 3)) tick();
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b1 || bus.INITIALIZE_BOARD !== 1'b0) begin
            n_err++; $display("FAIL boot_begin_hold bg=%0d ib=%0d want 1,0", bus.BEGIN_GAME, bus.INITIALIZE_BOARD);
        end
        bus.ACK_BEGIN_GAME = 1; tick(); bus.ACK_BEGIN_GAME = 0;
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b0 || bus.MODE !== 1'b1 || bus.TOTAL_TRIES !== 8'd25) begin
            n_err++; $display("FAIL boot_done bg=%0d mode=%0d total=%0d want 0 1 25",
                              bus.BEGIN_GAME, bus.MODE, bus.TOTAL_TRIES);
        end
        bus.INITIALIZED = 1;
    endtask

    task automatic test_menu();
        int r;
        go_menu();
        press(0, 0, 1, 0, 0);
        n_vec++;
        if (bus.SORC !== 1'b1) begin n_err++; $display("FAIL menu_sorc got %0d want 1", bus.SORC); end
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: press(1, 0, 0, 0, 0);
                1: press(0, 1, 0, 0, 0);
                2: press(0, 0, 1, 0, 0);
                3: press(1, 1, 0, 0, 0);
                default: press(1, 0, 1, 0, 0);
            endcase
            n_vec++;
            if (bus.SIZE !== 5'(m_size) || bus.COLOR_NUM !== 4'(m_cnum) || bus.SORC !== 1'(m_sorc)) begin
                n_err++; $display("FAIL menu_rand[%0d] op=%0d got %0d %0d %0d want %0d %0d %0d", k, r,
                                  bus.SIZE, bus.COLOR_NUM, bus.SORC, m_size, m_cnum, m_sorc);
            end
        end
        set_fields(26, 8);
        press(0, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        n_vec++;
        if (bus.SIZE !== 5'd2) begin n_err++; $display("FAIL size_wrap_up got %0d want 2", bus.SIZE); end
        press(0, 1, 0, 0, 0);
        n_vec++;
        if (bus.SIZE !== 5'd26) begin n_err++; $display("FAIL size_wrap_dn got %0d want 26", bus.SIZE); end
        press(0, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        n_vec++;
        if (bus.COLOR_NUM !== 4'd3) begin n_err++; $display("FAIL cnum_wrap_up got %0d want 3", bus.COLOR_NUM); end
        press(0, 0, 0, 1, 0);
        n_vec++;
        if (bus.MODE !== 1'b1 || bus.FINAL_SIZE !== 5'(m_fsize) || bus.FINAL_COLOR_NUM !== 4'(m_fcnum)) begin
            n_err++; $display("FAIL menu_exit mode=%0d fs=%0d fc=%0d want 1 %0d %0d",
                              bus.MODE, bus.FINAL_SIZE, bus.FINAL_COLOR_NUM, m_fsize, m_fcnum);
        end
    endtask

    task automatic hold(input int up, input int n);
        if (up != 0) bus.UP = 1; else bus.DOWN = 1;
        repeat (n) tick();
        bus.UP = 0; bus.DOWN = 0;
        tick();
        for (int k = 0; k < hold_steps(n); k++) begin
            if (m_sorc == 1) m_size = wrap_size(m_size, (up != 0) ? 1 : -1);
            else             m_cnum = wrap_cnum(m_cnum, (up != 0) ? 1 : -1);
        end
    endtask

    task automatic test_repeat();
        int n, up;
        go_menu();
        set_fields(m_size, 6);
        hold(1, D + 2 * P + 1);
        n_vec++;
        if (bus.COLOR_NUM !== 4'(m_cnum) || m_cnum != 4) begin
            n_err++; $display("FAIL repeat_4steps got %0d want %0d", bus.COLOR_NUM, m_cnum);
        end
        hold(1, D + 2 * P);
        n_vec++;
        if (bus.COLOR_NUM !== 4'(m_cnum)) begin
            n_err++; $display("FAIL repeat_3steps got %0d want %0d", bus.COLOR_NUM, m_cnum);
        end
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, D + 3 * P);
            up = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) press(0, 0, 1, 0, 0);
            hold(up, n);
            n_vec++;
            if (bus.SIZE !== 5'(m_size) || bus.COLOR_NUM !== 4'(m_cnum)) begin
                n_err++; $display("FAIL repeat_rand[%0d] n=%0d got %0d %0d want %0d %0d", k, n,
                                  bus.SIZE, bus.COLOR_NUM, m_size, m_cnum);
            end
        end
        press(0, 0, 0, 1, 0);
    endtask

    task automatic test_budget();
        int ws, wc;
        for (int k = 0; k < 4; k++) begin
            ws = SMIN + SSTEP * $urandom_range(0, 6);
            wc = $urandom_range(CMIN, NCMAX);
            go_menu();
            set_fields(ws, wc);
            start_game();
            n_vec++;
            if (bus.FINAL_SIZE !== 5'(ws) || bus.FINAL_COLOR_NUM !== 4'(wc)
                || bus.TOTAL_TRIES !== 8'(model_budget(ws, wc))) begin
                n_err++; $display("FAIL budget_rand s=%0d c=%0d got %0d %0d %0d want %0d", ws, wc,
                                  bus.FINAL_SIZE, bus.FINAL_COLOR_NUM, bus.TOTAL_TRIES, model_budget(ws, wc));
            end
        end
        go_menu();
        set_fields(2, 3);
        start_game();
        n_vec++;
        if (bus.FINAL_SIZE !== 5'd2 || bus.TOTAL_TRIES !== 8'd1) begin
            n_err++; $display("FAIL budget_min fs=%0d total=%0d want 2 1", bus.FINAL_SIZE, bus.TOTAL_TRIES);
        end
        bus.SW[0] = ~bus.SW[0]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b1 || bus.COLOR_SELECTED !== 3'd0 || bus.TRIES !== 8'd1) begin
            n_err++; $display("FAIL one_move sel=%0d csel=%0d tries=%0d want 1 0 1",
                              bus.COLOR_SEL_SIG, bus.COLOR_SELECTED, bus.TRIES);
        end
        bus.CURRENTLY_CHANGING_COLOR = 1; tick(); bus.CURRENTLY_CHANGING_COLOR = 0;
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0) begin n_err++; $display("FAIL sel_ack got %0d want 0", bus.COLOR_SEL_SIG); end
        tick();
        bus.SW[1] = ~bus.SW[1]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0 || bus.TRIES !== 8'd1 || bus.OUT_OF_TRIES !== 1'b1) begin
            n_err++; $display("FAIL out_of_tries sel=%0d tries=%0d oot=%0d want 0 1 1",
                              bus.COLOR_SEL_SIG, bus.TRIES, bus.OUT_OF_TRIES);
        end
        bus.GAME_OVER = 1; #1;
        n_vec++;
        if (bus.OUT_OF_TRIES !== 1'b0) begin n_err++; $display("FAIL oot_game_over got %0d want 0", bus.OUT_OF_TRIES); end
        bus.GAME_OVER = 0;
        m_tries = 1; m_sel = 0; m_csel = 0;
    endtask

    task automatic test_moves();
        int flip, cand, ccc, go, issue;
        go_menu();
        bus.SW = bus.SW ^ 8'hA5; tick(); tick();
        set_fields(26, 4);
        press(0, 0, 0, 1, 0);
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0) begin n_err++; $display("FAIL menu_sw_dropped got %0d want 0", bus.COLOR_SEL_SIG); end
        go_menu();
        start_game();
        n_vec++;
        if (bus.TOTAL_TRIES !== 8'(model_budget(26, 4))) begin
            n_err++; $display("FAIL budget_26x4 got %0d want %0d", bus.TOTAL_TRIES, model_budget(26, 4));
        end
        bus.SW[5] = ~bus.SW[5]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0) begin n_err++; $display("FAIL sw5_ignored got %0d want 0", bus.COLOR_SEL_SIG); end
        bus.SW[6] = ~bus.SW[6]; bus.SW[2] = ~bus.SW[2]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b1 || bus.COLOR_SELECTED !== 3'd2 || bus.TRIES !== 8'd1) begin
            n_err++; $display("FAIL sw62_lowest sel=%0d csel=%0d tries=%0d want 1 2 1",
                              bus.COLOR_SEL_SIG, bus.COLOR_SELECTED, bus.TRIES);
        end
        m_sel = 1; m_csel = 2; m_tries = 1;
        for (int k = 0; k < 50; k++) begin
            flip = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 255) | (1 << $urandom_range(0, 7)));
            ccc  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            go   = ($urandom_range(0, 11) == 0) ? 1 : 0;
            bus.SW = bus.SW ^ 8'(flip);
            bus.CURRENTLY_CHANGING_COLOR = 1'(ccc);
            bus.GAME_OVER = 1'(go);
            cand  = flip & ((1 << m_fcnum) - 1);
            issue = (cand != 0 && m_sel == 0 && ccc == 0 && go == 0 && m_tries < total_now()) ? 1 : 0;
            if (issue == 1) begin
                m_sel = 1; m_csel = $clog2(cand & (~cand + 1)); m_tries++;
            end else if (m_sel == 1 && ccc == 1) begin
                m_sel = 0;
            end
            tick();
            n_vec++;
            if (bus.COLOR_SEL_SIG !== 1'(m_sel) || bus.COLOR_SELECTED !== 3'(m_csel) || bus.TRIES !== 8'(m_tries)
                || bus.OUT_OF_TRIES !== ((m_tries == total_now()) && go == 0)) begin
                n_err++; $display("FAIL moves_rand[%0d] got sel=%0d csel=%0d tries=%0d oot=%0d want %0d %0d %0d", k,
                                  bus.COLOR_SEL_SIG, bus.COLOR_SELECTED, bus.TRIES, bus.OUT_OF_TRIES,
                                  m_sel, m_csel, m_tries);
            end
        end
        bus.GAME_OVER = 0;
        bus.CURRENTLY_CHANGING_COLOR = 1; tick();
        m_sel = 0;
        bus.SW[1] = ~bus.SW[1]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0 || bus.TRIES !== 8'(m_tries)) begin
            n_err++; $display("FAIL busy_dropped sel=%0d tries=%0d want 0 %0d", bus.COLOR_SEL_SIG, bus.TRIES, m_tries);
        end
        bus.CURRENTLY_CHANGING_COLOR = 0; tick();
    endtask

    task automatic test_reset_mid();
        rst_n = 0; #1;
        model_reset();
        tick(); rst_n = 1; tick(); tick();
        bus.SW[0] = ~bus.SW[0]; tick();
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b1 || bus.MODE !== 1'b1) begin
            n_err++; $display("FAIL pre_rst_sel sel=%0d mode=%0d want 1 1", bus.COLOR_SEL_SIG, bus.MODE);
        end
        rst_n = 0; #1;
        n_vec++;
        if (bus.COLOR_SEL_SIG !== 1'b0) begin n_err++; $display("FAIL rst_sel_drop got %0d want 0", bus.COLOR_SEL_SIG); end
        tick(); rst_n = 1; tick(); tick();
        go_menu();
        press(0, 0, 0, 0, 1);
        n_vec++;
        if (bus.INITIALIZE_BOARD !== 1'b1) begin n_err++; $display("FAIL rst_ib_pre got %0d want 1", bus.INITIALIZE_BOARD); end
        rst_n = 0; #1;
        n_vec++;
        if (bus.INITIALIZE_BOARD !== 1'b0) begin n_err++; $display("FAIL rst_ib_drop got %0d want 0", bus.INITIALIZE_BOARD); end
        tick(); rst_n = 1; tick(); tick();
        go_menu();
        press(0, 0, 0, 0, 1);
        bus.BOARD_READY = 1; tick(); bus.BOARD_READY = 0;
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b1) begin n_err++; $display("FAIL rst_bg_pre got %0d want 1", bus.BEGIN_GAME); end
        rst_n = 0; #1;
        n_vec++;
        if (bus.BEGIN_GAME !== 1'b0) begin n_err++; $display("FAIL rst_bg_drop got %0d want 0", bus.BEGIN_GAME); end
        tick(); rst_n = 1; tick();
    endtask

    initial begin
        test_reset();
        test_menu();
        test_repeat();
        test_budget();
        test_moves();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
